// File: rtl/store_align_buffer.sv
// Store queue between MEM stage and data memory: aligns store data and active-low byte enables to DM lanes,
// splits lane-crossing stores into two beats and flags loads that overlap queued stores.
module store_align_buffer #(
    parameter int         DATA_W         = 32,
    parameter int         DEPTH          = 4,
    parameter bit         ALLOW_MISALIGN = 1'b1,
    parameter logic [2:0] WHB_WORD       = 3'b100,
    parameter logic [2:0] WHB_HALF       = 3'b010,
    parameter logic [2:0] WHB_BYTE       = 3'b001
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   st_valid,
    output logic                   st_ready,
    input  logic [31:0]            st_addr,
    input  logic [31:0]            st_data,
    input  logic [2:0]             st_whb,
    output logic                   dm_valid,
    input  logic                   dm_ready,
    output logic [31:0]            DM_addr,
    output logic [DATA_W/8-1:0]    DM_web,
    output logic [DATA_W-1:0]      DM_datain,
    input  logic [31:0]            ld_addr,
    output logic                   ld_hit,
    output logic                   misalign_err,
    output logic                   empty
);
    localparam int LANES = DATA_W / 8;
    localparam int OFFW  = $clog2(LANES);
    localparam int PTRW  = $clog2(DEPTH);
    localparam logic [31:0] ALIGN_MASK = ~(32'(LANES) - 32'd1);

    typedef enum logic {BEAT0 = 1'b0, BEAT1 = 1'b1} beat_t;

    logic [31:0]     addr_q_r  [DEPTH];
    logic [31:0]     data_q_r  [DEPTH];
    logic [2:0]      n_q_r     [DEPTH];
    logic            split_q_r [DEPTH];
    logic [PTRW-1:0] rd_ptr_r;
    logic [PTRW-1:0] wr_ptr_r;
    logic [PTRW:0]   count_r;
    beat_t           beat_r;
    logic            misalign_err_r;

    logic [2:0]          n_s;
    logic                size_ok_s;
    logic [31:0]         data_mask_s;
    logic [OFFW+1:0]     span_s;
    logic                split_s;
    logic                accept_s;
    logic                push_s;
    logic                drop_s;
    logic                pop_s;
    logic                hs_s;
    logic [OFFW-1:0]     head_off_s;
    logic [3:0]          lane_ones_s;
    logic [2*LANES-1:0]  head_mask_s;
    logic [2*DATA_W-1:0] head_wide_s;
    logic [31:0]         head_aligned_s;
    logic                ld_hit_s;

    // Decode incoming store size and zero the bytes beyond it so unused lanes carry 0.
    always_comb begin
        size_ok_s   = 1'b1;
        n_s         = 3'd0;
        data_mask_s = 32'h0000_0000;
        case (st_whb)
            WHB_WORD: begin n_s = 3'd4; data_mask_s = st_data; end
            WHB_HALF: begin n_s = 3'd2; data_mask_s = {16'h0000, st_data[15:0]}; end
            WHB_BYTE: begin n_s = 3'd1; data_mask_s = {24'h00_0000, st_data[7:0]}; end
            default:  begin n_s = 3'd0; size_ok_s = 1'b0; end
        endcase
    end

    assign span_s   = (OFFW+2)'(st_addr[OFFW-1:0]) + (OFFW+2)'(n_s);
    assign split_s  = span_s > (OFFW+2)'(LANES);
    assign st_ready = count_r != (PTRW+1)'(DEPTH);
    assign accept_s = st_valid && st_ready;
    assign drop_s   = accept_s && size_ok_s && split_s && !ALLOW_MISALIGN;
    assign push_s   = accept_s && size_ok_s && !(split_s && !ALLOW_MISALIGN);
    assign hs_s     = dm_valid && dm_ready;
    assign pop_s    = hs_s && ((beat_r == BEAT1) || !split_q_r[rd_ptr_r]);

    // Head entry expanded over two DM words: low half is beat0, high half is beat1.
    always_comb begin
        head_off_s     = addr_q_r[rd_ptr_r][OFFW-1:0];
        head_aligned_s = addr_q_r[rd_ptr_r] & ALIGN_MASK;
        case (n_q_r[rd_ptr_r])
            3'd4:    lane_ones_s = 4'hF;
            3'd2:    lane_ones_s = 4'h3;
            3'd1:    lane_ones_s = 4'h1;
            default: lane_ones_s = 4'h0;
        endcase
        head_mask_s = (2*LANES)'(lane_ones_s) << head_off_s;
        head_wide_s = (2*DATA_W)'(data_q_r[rd_ptr_r]) << {head_off_s, 3'b000};
    end

    // DM beat outputs, idle values whenever the queue is empty.
    always_comb begin
        dm_valid  = 1'b0;
        DM_addr   = 32'h0000_0000;
        DM_web    = {LANES{1'b1}};
        DM_datain = {DATA_W{1'b0}};
        if (count_r != '0) begin
            dm_valid = 1'b1;
            if (beat_r == BEAT0) begin
                DM_addr   = head_aligned_s;
                DM_web    = ~head_mask_s[LANES-1:0];
                DM_datain = head_wide_s[DATA_W-1:0];
            end else begin
                DM_addr   = head_aligned_s + 32'(LANES);
                DM_web    = ~head_mask_s[2*LANES-1:LANES];
                DM_datain = head_wide_s[2*DATA_W-1:DATA_W];
            end
        end else begin
            dm_valid = 1'b0;
        end
    end

    // Load overlap: any live entry whose first or (split) second word matches the load word.
    always_comb begin
        ld_hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ld_hit_s = ld_hit_s |
                (({1'b0, PTRW'(PTRW'(i) - rd_ptr_r)} < count_r) &&
                 (((addr_q_r[i] & ALIGN_MASK) == (ld_addr & ALIGN_MASK)) ||
                  (split_q_r[i] && (((addr_q_r[i] & ALIGN_MASK) + 32'(LANES)) == (ld_addr & ALIGN_MASK)))));
        end
    end

    assign ld_hit       = ld_hit_s;
    assign misalign_err = misalign_err_r;
    assign empty        = count_r == '0;

    // Queue storage, pointers, occupancy and beat state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r       <= '0;
            wr_ptr_r       <= '0;
            count_r        <= '0;
            beat_r         <= BEAT0;
            misalign_err_r <= 1'b0;
        end else begin
            misalign_err_r <= drop_s;
            if (push_s) begin
                addr_q_r[wr_ptr_r]  <= st_addr;
                data_q_r[wr_ptr_r]  <= data_mask_s;
                n_q_r[wr_ptr_r]     <= n_s;
                split_q_r[wr_ptr_r] <= split_s;
                wr_ptr_r            <= wr_ptr_r + PTRW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTRW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTRW+1)'(1);
                2'b01:   count_r <= count_r - (PTRW+1)'(1);
                default: count_r <= count_r;
            endcase
            case (beat_r)
                BEAT0:   if (hs_s && split_q_r[rd_ptr_r]) beat_r <= BEAT1;
                BEAT1:   if (dm_ready) beat_r <= BEAT0;
                default: beat_r <= BEAT0;
            endcase
        end
    end
endmodule

// File: tb/tb_store_align_buffer.sv
// Directed bench for store_align_buffer: one instance with misaligned splitting, one that drops misaligned stores.
module tb_store_align_buffer;
    localparam logic [2:0] W = 3'b100;
    localparam logic [2:0] H = 3'b010;
    localparam logic [2:0] B = 3'b001;

    logic        clk = 1'b0;
    logic        rst, st_valid, dm_ready;
    logic [31:0] st_addr, st_data, ld_addr;
    logic [2:0]  st_whb;

    logic        st_ready, dm_valid, ld_hit, misalign_err, empty;
    logic [31:0] DM_addr, DM_datain;
    logic [3:0]  DM_web;
    logic        nm_st_ready, nm_dm_valid, nm_ld_hit, nm_misalign_err, nm_empty;
    logic [31:0] nm_DM_addr, nm_DM_datain;
    logic [3:0]  nm_DM_web;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    store_align_buffer #(.DATA_W(32), .DEPTH(4), .ALLOW_MISALIGN(1'b1)) dut (
        .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_whb(st_whb), .dm_valid(dm_valid), .dm_ready(dm_ready),
        .DM_addr(DM_addr), .DM_web(DM_web), .DM_datain(DM_datain), .ld_addr(ld_addr),
        .ld_hit(ld_hit), .misalign_err(misalign_err), .empty(empty));

    store_align_buffer #(.DATA_W(32), .DEPTH(4), .ALLOW_MISALIGN(1'b0)) dut_nm (
        .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(nm_st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_whb(st_whb), .dm_valid(nm_dm_valid), .dm_ready(dm_ready),
        .DM_addr(nm_DM_addr), .DM_web(nm_DM_web), .DM_datain(nm_DM_datain), .ld_addr(ld_addr),
        .ld_hit(nm_ld_hit), .misalign_err(nm_misalign_err), .empty(nm_empty));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] w);
        st_valid = 1'b1; st_addr = a; st_data = d; st_whb = w;
        step();
        st_valid = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [31:0] a, input logic [3:0] web, input logic [31:0] d);
        chk({tag, "_valid"}, dm_valid, 1'b1);
        chk({tag, "_addr"}, DM_addr, a);
        chk({tag, "_web"}, DM_web, web);
        chk({tag, "_data"}, DM_datain, d);
    endtask

    initial begin
        rst = 1'b1; st_valid = 1'b0; dm_ready = 1'b1;
        st_addr = 32'h0; st_data = 32'h0; st_whb = W; ld_addr = 32'h0;
        step(); step();
        rst = 1'b0;
        chk("rst_dm_valid", dm_valid, 1'b0);
        chk("rst_web", DM_web, 4'b1111);
        chk("rst_data", DM_datain, 32'h0);
        chk("rst_addr", DM_addr, 32'h0);
        chk("rst_ld_hit", ld_hit, 1'b0);
        chk("rst_st_ready", st_ready, 1'b1);
        chk("rst_empty", empty, 1'b1);
        chk("rst_misalign", misalign_err, 1'b0);

        // Misaligned word: dropped by dut_nm, split by dut
        push(32'h101, 32'hDEADBEEF, W);
        chk("nm_misalign_pulse", nm_misalign_err, 1'b1);
        chk("nm_empty", nm_empty, 1'b1);
        chk("nm_no_valid", nm_dm_valid, 1'b0);
        beat("mis_b0", 32'h100, 4'b0001, 32'hADBEEF00);
        step();
        chk("nm_misalign_clear", nm_misalign_err, 1'b0);
        chk("nm_empty2", nm_empty, 1'b1);
        beat("mis_b1", 32'h104, 4'b1110, 32'h000000DE);
        step();
        chk("mis_empty", empty, 1'b1);

        push(32'h100, 32'hA1B2C3D4, W);
        beat("word", 32'h100, 4'b0000, 32'hA1B2C3D4);
        step();
        chk("word_empty", empty, 1'b1);
        chk("word_idle_web", DM_web, 4'b1111);
        chk("word_idle_data", DM_datain, 32'h0);

        push(32'h102, 32'h00000055, B);
        beat("byte", 32'h100, 4'b1011, 32'h00550000);
        step();
        push(32'h102, 32'h0000BEEF, H);
        beat("half", 32'h100, 4'b0011, 32'hBEEF0000);
        step();
        chk("half_empty", empty, 1'b1);

        push(32'h103, 32'h00001234, H);
        beat("split_b0", 32'h100, 4'b0111, 32'h34000000);
        ld_addr = 32'h106; #1;
        chk("split_ld_hit_w1", ld_hit, 1'b1);
        ld_addr = 32'h0;
        step();
        beat("split_b1", 32'h104, 4'b1110, 32'h00000012);
        chk("split_misalign_none", misalign_err, 1'b0);
        step();
        chk("split_popped", empty, 1'b1);
        chk("split_popped_valid", dm_valid, 1'b0);

        // Fill with DM stalled, hold a fifth, then drain in order
        dm_ready = 1'b0;
        push(32'h100, 32'h11111111, W);
        push(32'h200, 32'h22222222, W);
        push(32'h301, 32'h00000077, B);
        chk("fill3_ready", st_ready, 1'b1);
        push(32'h402, 32'h00009999, H);
        chk("full_ready", st_ready, 1'b0);
        st_valid = 1'b1; st_addr = 32'h500; st_data = 32'h55555555; st_whb = W;
        step();
        chk("full_held_ready", st_ready, 1'b0);
        beat("stall_head", 32'h100, 4'b0000, 32'h11111111);
        ld_addr = 32'h100; #1;
        chk("ld_hit_match", ld_hit, 1'b1);
        ld_addr = 32'h600; #1;
        chk("ld_hit_nomatch", ld_hit, 1'b0);
        dm_ready = 1'b1;
        step();
        beat("drain1", 32'h200, 4'b0000, 32'h22222222);
        chk("drain1_ready", st_ready, 1'b1);
        ld_addr = 32'h100; #1;
        chk("ld_hit_after_pop", ld_hit, 1'b0);
        ld_addr = 32'h0;
        step();
        st_valid = 1'b0;
        beat("drain2", 32'h300, 4'b1101, 32'h00007700);
        step();
        beat("drain3", 32'h400, 4'b0011, 32'h99990000);
        step();
        beat("drain4", 32'h500, 4'b0000, 32'h55555555);
        step();
        chk("drain_empty", empty, 1'b1);
        chk("drain_no_valid", dm_valid, 1'b0);

        // Reset between beat0 and beat1 of a split store
        push(32'h103, 32'h0000ABCD, H);
        beat("rs_b0", 32'h100, 4'b0111, 32'hCD000000);
        step();
        beat("rs_b1", 32'h104, 4'b1110, 32'h000000AB);
        rst = 1'b1; dm_ready = 1'b0;
        step();
        rst = 1'b0;
        chk("rs_valid", dm_valid, 1'b0);
        chk("rs_web", DM_web, 4'b1111);
        chk("rs_empty", empty, 1'b1);
        dm_ready = 1'b1;
        step();
        chk("rs_no_beat1", dm_valid, 1'b0);
        chk("rs_st_ready", st_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
